// File: rtl/lca_pkg.sv
// Shared types and sizing helpers for the pair scheduler.
package lca_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int MIN_PAIR_ENTRIES = 2;

  function automatic int pair_count(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Width able to hold 0..depth-1, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lca_pair_counter.sv
// Lexicographic (i,j) generator over all unordered pairs i<j<n.
module lca_pair_counter #(
  parameter int AW = 3,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          step,
  input  logic [NW-1:0] n,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic          last
);

  logic [NW-1:0] i_ext;
  logic [NW-1:0] j_ext;
  logic          j_at_end;

  assign i_ext    = NW'(i);
  assign j_ext    = NW'(j);
  assign j_at_end = (j_ext == n - NW'(1));
  assign last     = j_at_end && (i_ext == n - NW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
    end else if (init) begin
      i <= '0;
      j <= AW'(1);
    end else if (step) begin
      if (j_at_end) begin
        i <= i + AW'(1);
        j <= i + AW'(2);
      end else begin
        j <= j + AW'(1);
      end
    end
  end

endmodule

// File: rtl/lca_pair_scheduler.sv
// Sweeps every unordered pair of stored (subject, object) tuples through one
// shared checker and accumulates the match count and first matching pair.
//
//   state   | meaning
//   S_IDLE  | table writable, waiting for start
//   S_ISSUE | pair request presented, waiting for chk_ready
//   S_WAIT  | request accepted, waiting for rsp_valid
//   S_DONE  | one-cycle done pulse, then back to idle
module lca_pair_scheduler
  import lca_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int SUBJ_W      = 4,
  parameter int OBJ_W       = 4,
  localparam int AW         = idx_width(NUM_ENTRIES),
  localparam int NW         = idx_width(NUM_ENTRIES + 1),
  localparam int NUM_PAIRS  = pair_count(NUM_ENTRIES),
  localparam int CW         = idx_width(NUM_PAIRS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [SUBJ_W-1:0] wr_subject,
  input  logic [OBJ_W-1:0]  wr_object,
  input  logic [NW-1:0]     num_valid,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              chk_valid,
  input  logic              chk_ready,
  output logic [SUBJ_W-1:0] chk_subject1,
  output logic [OBJ_W-1:0]  chk_object1,
  output logic [SUBJ_W-1:0] chk_subject2,
  output logic [OBJ_W-1:0]  chk_object2,
  input  logic              rsp_valid,
  input  logic              rsp_is_linear,
  output logic [CW-1:0]     match_count,
  output logic              first_found,
  output logic [AW-1:0]     first_i,
  output logic [AW-1:0]     first_j
);

  state_t            state;
  logic [SUBJ_W-1:0] tbl_subject [NUM_ENTRIES];
  logic [OBJ_W-1:0]  tbl_object  [NUM_ENTRIES];
  logic [NW-1:0]     n_eff;
  logic [NW-1:0]     n_q;
  logic [AW-1:0]     pair_i;
  logic [AW-1:0]     pair_j;
  logic              pair_last;
  logic              cnt_init;
  logic              cnt_step;

  assign n_eff    = (num_valid > NW'(NUM_ENTRIES)) ? NW'(NUM_ENTRIES) : num_valid;
  assign cnt_init = (state == S_IDLE) && start && (n_eff >= NW'(MIN_PAIR_ENTRIES));
  assign cnt_step = (state == S_WAIT) && rsp_valid && !pair_last;

  // Table is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      tbl_subject[wr_addr] <= wr_subject;
      tbl_object[wr_addr]  <= wr_object;
    end
  end

  // Read straight from the table so a write on the start cycle is seen.
  assign chk_subject1 = chk_valid ? tbl_subject[pair_i] : '0;
  assign chk_object1  = chk_valid ? tbl_object[pair_i]  : '0;
  assign chk_subject2 = chk_valid ? tbl_subject[pair_j] : '0;
  assign chk_object2  = chk_valid ? tbl_object[pair_j]  : '0;

  lca_pair_counter #(.AW(AW), .NW(NW)) u_pair_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (cnt_init),
    .step  (cnt_step),
    .n     (n_q),
    .i     (pair_i),
    .j     (pair_j),
    .last  (pair_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      chk_valid   <= 1'b0;
      n_q         <= '0;
      match_count <= '0;
      first_found <= 1'b0;
      first_i     <= '0;
      first_j     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q         <= n_eff;
            match_count <= '0;
            first_found <= 1'b0;
            first_i     <= '0;
            first_j     <= '0;
            busy        <= 1'b1;
            if (n_eff >= NW'(MIN_PAIR_ENTRIES)) begin
              state     <= S_ISSUE;
              chk_valid <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (chk_ready) begin
            state     <= S_WAIT;
            chk_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            if (rsp_is_linear) begin
              match_count <= match_count + CW'(1);
              if (!first_found) begin
                first_found <= 1'b1;
                first_i     <= pair_i;
                first_j     <= pair_j;
              end
            end
            if (pair_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              chk_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lca_pair_scheduler.sv
// Directed bench for lca_pair_scheduler with a cycle-stepped checker model.
module tb_lca_pair_scheduler;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int NW = 4;
  localparam int SW = 4;
  localparam int OW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_subject;
  logic [OW-1:0] wr_object;
  logic [NW-1:0] num_valid;
  logic          start;
  logic          busy;
  logic          done;
  logic          chk_valid;
  logic          chk_ready;
  logic [SW-1:0] chk_subject1;
  logic [OW-1:0] chk_object1;
  logic [SW-1:0] chk_subject2;
  logic [OW-1:0] chk_object2;
  logic          rsp_valid;
  logic          rsp_is_linear;
  logic [CW-1:0] match_count;
  logic          first_found;
  logic [AW-1:0] first_i;
  logic [AW-1:0] first_j;

  int n_checks = 0;
  int n_errors = 0;
  int tsub [N];
  int tobj [N];
  bit match_m [N][N];

  lca_pair_scheduler #(.NUM_ENTRIES(N), .SUBJ_W(SW), .OBJ_W(OW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_subject    (wr_subject),
    .wr_object     (wr_object),
    .num_valid     (num_valid),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .chk_valid     (chk_valid),
    .chk_ready     (chk_ready),
    .chk_subject1  (chk_subject1),
    .chk_object1   (chk_object1),
    .chk_subject2  (chk_subject2),
    .chk_object2   (chk_object2),
    .rsp_valid     (rsp_valid),
    .rsp_is_linear (rsp_is_linear),
    .match_count   (match_count),
    .first_found   (first_found),
    .first_i       (first_i),
    .first_j       (first_j)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, " busy"},        busy,         0);
    check_eq({tag, " done"},        done,         0);
    check_eq({tag, " chk_valid"},   chk_valid,    0);
    check_eq({tag, " subj1"},       chk_subject1, 0);
    check_eq({tag, " obj1"},        chk_object1,  0);
    check_eq({tag, " subj2"},       chk_subject2, 0);
    check_eq({tag, " obj2"},        chk_object2,  0);
    check_eq({tag, " match_count"}, match_count,  0);
    check_eq({tag, " first_found"}, first_found,  0);
    check_eq({tag, " first_i"},     first_i,      0);
    check_eq({tag, " first_j"},     first_j,      0);
  endtask

  task automatic check_pair(input string tag, input int ei, input int ej);
    check_eq({tag, " valid"}, chk_valid,    1);
    check_eq({tag, " subj1"}, chk_subject1, tsub[ei]);
    check_eq({tag, " obj1"},  chk_object1,  tobj[ei]);
    check_eq({tag, " subj2"}, chk_subject2, tsub[ej]);
    check_eq({tag, " obj2"},  chk_object2,  tobj[ej]);
  endtask

  // One sweep: stall = cycles chk_ready held low per request, rdly = response
  // delay after acceptance (>=1), abort_k = pair whose WAIT gets a reset (-1 none).
  task automatic sweep(input int nv, input int stall, input int rdly, input bit spur,
                       input bit poke, input int abort_k, input bit wr_at_start);
    int    n, p, ei, ej, exp_cnt, efi, efj;
    bit    eff;
    string tag;
    n = (nv > N) ? N : nv;
    p = (n * (n - 1)) / 2;
    @(negedge clk);
    start     = 1'b1;
    num_valid = NW'(nv);
    if (wr_at_start) begin
      wr_en = 1'b1; wr_addr = 3'd1; wr_subject = 4'd10; wr_object = 4'd5;
      tsub[1] = 10; tobj[1] = 5;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; num_valid = '0;
    check_eq($sformatf("nv%0d busy_after_start", nv), busy, 1);
    ei = 0; ej = 1; exp_cnt = 0; eff = 0; efi = 0; efj = 0;
    for (int k = 0; k < p; k++) begin
      tag = $sformatf("nv%0d pair%0d(%0d,%0d)", nv, k, ei, ej);
      chk_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check_pair({tag, " stalled"}, ei, ej);
        if (spur && s == 0) begin
          rsp_valid = 1'b1; rsp_is_linear = 1'b1;
        end
        @(negedge clk);
        rsp_valid = 1'b0; rsp_is_linear = 1'b0;
      end
      check_pair(tag, ei, ej);
      chk_ready = 1'b1;
      @(negedge clk);
      chk_ready = 1'b0;
      for (int d = 1; d < rdly; d++) begin
        check_eq({tag, " one_outstanding"}, chk_valid, 0);
        if (poke && k == 3 && d == 1) begin
          start = 1'b1; num_valid = 4'd2;
          wr_en = 1'b1; wr_addr = 3'd7; wr_subject = 4'd15; wr_object = 4'd15;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; num_valid = '0;
      end
      check_eq({tag, " wait_valid"}, chk_valid, 0);
      check_eq({tag, " wait_done"},  done,      0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        check_reset_outs({tag, " abort"});
        @(negedge clk);
        check_reset_outs({tag, " abort_hold"});
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs({tag, " abort_released"});
        return;
      end
      rsp_valid     = 1'b1;
      rsp_is_linear = match_m[ei][ej];
      if (match_m[ei][ej]) begin
        exp_cnt++;
        if (!eff) begin eff = 1; efi = ei; efj = ej; end
      end
      @(negedge clk);
      rsp_valid = 1'b0; rsp_is_linear = 1'b0;
      if (ej == n - 1) begin ei++; ej = ei + 1; end
      else ej++;
    end
    tag = $sformatf("nv%0d end", nv);
    check_eq({tag, " done"},        done,        1);
    check_eq({tag, " busy"},        busy,        1);
    check_eq({tag, " chk_valid"},   chk_valid,   0);
    check_eq({tag, " match_count"}, match_count, exp_cnt);
    check_eq({tag, " first_found"}, first_found, eff);
    check_eq({tag, " first_i"},     first_i,     efi);
    check_eq({tag, " first_j"},     first_j,     efj);
    @(negedge clk);
    check_eq({tag, " done_cleared"}, done, 0);
    check_eq({tag, " idle"},         busy, 0);
    check_eq({tag, " count_held"},   match_count, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_subject = '0; wr_object = '0;
    num_valid = '0; start = 1'b0; chk_ready = 1'b0; rsp_valid = 1'b0; rsp_is_linear = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("post_reset");

    for (int k = 0; k < N; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_subject = SW'(k); wr_object = OW'(7 - k);
      tsub[k] = k; tobj[k] = 7 - k;
      @(negedge clk);
    end
    wr_en = 1'b0;

    // Full sweep, checker always says no: pair k at cycle 1+2k, done at 57.
    sweep(8, 0, 1, 0, 0, -1, 0);

    // Matches at (2,5) and (4,6); entry 1 rewritten on the start cycle.
    match_m[2][5] = 1'b1;
    match_m[4][6] = 1'b1;
    sweep(8, 0, 1, 0, 0, -1, 1);

    // Degenerate table sizes clear previous results without issuing.
    sweep(1, 0, 1, 0, 0, -1, 0);
    sweep(8, 0, 1, 0, 0, -1, 0);
    sweep(0, 0, 1, 0, 0, -1, 0);

    // Backpressure, slow checker, spurious responses, mid-sweep pokes, clamped n.
    sweep(12, 3, 4, 1, 1, -1, 0);

    // Reset in WAIT of pair 10 after an earlier match at (0,3), then a fresh sweep.
    match_m[0][3] = 1'b1;
    sweep(8, 0, 1, 0, 0, 10, 0);
    sweep(5, 0, 1, 0, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
